// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider (DIV); DIVU added when DIV_UNSIGNED_EN is defined.
// Latency: start sampled at edge N, hi/lo valid with done at edge N+WIDTH+1.
// Backpressure: none; start is ignored while busy, div_zero pulses instead of a result for b==0.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic              is_unsigned;
    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [WIDTH:0]    rem_shift, diff;

`ifdef DIV_UNSIGNED_EN
    assign is_unsigned = div_unsigned;
`else
    assign is_unsigned = 1'b0;
`endif

    // Magnitudes are exact in WIDTH unsigned bits, including the most negative value.
    assign abs_a = (a[WIDTH-1] && !is_unsigned) ? -a : a;
    assign abs_b = (b[WIDTH-1] && !is_unsigned) ? -b : b;

    // One extra bit keeps the compare correct for divisors at or above 2^(WIDTH-1).
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        quo_d     = abs_a;
                        dvs_d     = abs_b;
                        rem_d     = '0;
                        neg_quo_d = !is_unsigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = !is_unsigned && a[WIDTH-1];
                        cnt_d     = CW'(WIDTH);
                        busy_d    = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
`ifdef DIV_UNSIGNED_EN
    logic        div_unsigned;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          zero;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    div_unit #(.WIDTH(32)) dut (
        .clock    (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned (div_unsigned),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done or div_zero pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && (done === 1'b1 || div_zero === 1'b1)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: done=%0b div_zero=%0b with nothing expected", done, div_zero);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_div_zero"}, {31'b0, div_zero}, {31'b0, mon_e.zero});
                chk({mon_e.name, "_done"},     {31'b0, done},     {31'b0, !mon_e.zero});
                chk({mon_e.name, "_hi"}, hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, lo, mon_e.lo);
            end
        end
    end

    task automatic push(input string name, input bit zero, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.zero = zero;
        e.hi   = ehi;
        e.lo   = elo;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Drive start for one cycle; returns at the negedge just after the sampling edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done after an issue, checking latency, busy span and absence of div_zero.
    task automatic wait_done(input string name);
        int cycles = 0;
        int busy_cycles;
        int dz_seen = 0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (div_zero === 1'b1) dz_seen++;
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cycles++;
        end
        if (cycles >= 100) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, cycles);
        end else begin
            chk({name, "_latency"}, 32'(cycles), 32'd33);
            chk({name, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
            chk({name, "_busy_after"}, {31'b0, busy}, 32'd0);
            chk({name, "_no_div_zero"}, 32'(dz_seen), 32'd0);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ehi, input logic [31:0] elo);
        push(name, 1'b0, ehi, elo);
        issue(ia, ib);
        wait_done(name);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef DIV_UNSIGNED_EN
        div_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_div_zero", {31'b0, div_zero}, 32'h0);
        reset = 1'b1;

        run_op("p100_7",   32'd100,        32'd7,          32'd2,          32'd14);
        run_op("m7_2",     32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD);
        run_op("p7_m2",    32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD);
        run_op("m100_m7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14);
        run_op("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000);
        run_op("big_dvs",  32'h7FFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  32'h0);
        run_op("min_min",  32'h8000_0000,  32'h8000_0000,  32'h0,          32'h1);
        run_op("p100_7b",  32'd100,        32'd7,          32'd2,          32'd14);

        // Divide by zero: one-cycle flag, no busy, result registers untouched.
        push("zero", 1'b1, 32'd2, 32'd14);
        issue(32'd5, 32'd0);
        chk("zero_busy", {31'b0, busy}, 32'h0);
        chk("zero_pulse", {31'b0, div_zero}, 32'h1);
        @(negedge clk);
        chk("zero_pulse_end", {31'b0, div_zero}, 32'h0);
        chk("zero_busy2", {31'b0, busy}, 32'h0);
        chk("zero_hi_hold", hi, 32'd2);
        chk("zero_lo_hold", lo, 32'd14);

        // A start while busy is dropped; one issued during done is accepted.
        push("busy_ign", 1'b0, 32'd2, 32'd14);
        issue(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (done !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("busy_ign_seen_done", {31'b0, done}, 32'h1);
        end
        push("done_cycle", 1'b0, 32'd0, 32'd3);
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_cycle");

        // Reset mid-division aborts with no done.
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_done", {31'b0, done}, 32'h0);
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_done", {31'b0, done}, 32'h0);
        run_op("after_rst", 32'd100, 32'd7, 32'd2, 32'd14);

`ifdef DIV_UNSIGNED_EN
        div_unsigned = 1'b1;
        run_op("divu", 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF);
        div_unsigned = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed integer divider for the MIPS multi-cycle datapath; implements DIV.
- Consumes register A (dividend) and register B (divisor) and produces remainder/quotient on its hi/lo outputs, which feed the HI/LO write-select muxes.
- Raises div_zero toward the control unit for the divide-by-zero exception.
- Handshake with the control unit: single start pulse in, single done pulse out.

Parameters:
- WIDTH, 32, operand/result width in bits; also the number of iteration cycles.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  input  1  one-cycle request; a and b are sampled on the same edge.
- a  input  WIDTH  dividend (register A), two's complement.
- b  input  WIDTH  divisor (register B), two's complement.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; hi/lo are valid and updated.
- div_zero  output  1  one-cycle pulse; divide-by-zero detected, no result produced.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; internal registers cleared. Reset mid-operation aborts the division and produces no done pulse.
- States: IDLE, RUN, FIX.
- IDLE, start==1, b==0:
  - div_zero=1 for exactly one cycle after the edge.
  - State stays IDLE; busy stays 0; hi/lo unchanged; done not asserted.
- IDLE, start==1, b!=0:
  - Latch |a| and |b| as unsigned magnitudes, plus sign_q=a[MSB]^b[MSB] and sign_r=a[MSB].
  - Clear the partial remainder; counter=WIDTH; busy=1; go to RUN.
- IDLE, start==0: hold all outputs; done=0 and div_zero=0.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - If rem >= |b|: rem -= |b| and set quo LSB to 1.
  - Counter decrements each step. After the WIDTH-th step, go to FIX.
- FIX:
  - lo = sign_q ? -quo : quo.
  - hi = sign_r ? -rem : rem.
  - done=1 for one cycle; busy=0; go to IDLE.
- Timing: start sampled at edge N.
  - Iterations occur on edges N+1..N+WIDTH.
  - hi/lo update and done rises at edge N+WIDTH+1, so total latency is WIDTH+1 edges.
  - busy is high from edge N to edge N+WIDTH+1.
- start while busy==1 is ignored; there is no queueing and the operation in flight is unaffected. start in the same cycle that done is high is accepted, because the state is then IDLE.
- Semantics:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Invariant: a == lo*b + hi.
- Overflow case a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0. No flag, no exception.
- Magnitudes are computed in WIDTH bits unsigned, so |0x80000000| = 0x80000000 is exact.
- Subtraction uses WIDTH+1 bits so rem >= |b| is correct for |b| >= 2^(WIDTH-1).
- hi/lo hold their value until the next done or reset.

Optional Feature:
- DIV_UNSIGNED_EN.
- When defined:
  - Extra input port div_unsigned (1 bit) is sampled with start.
  - When div_unsigned is 1, a and b are treated as unsigned magnitudes (no abs) and sign_q=sign_r=0, which implements DIVU.
  - Latency, handshake and the div_zero rule are unchanged.
- When not defined: the port is absent and every operation is signed.

Test Plan:
- a=100, b=7, start pulse -> done exactly WIDTH+1 edges later (33), lo=14, hi=2, busy high for 33 cycles, div_zero never high.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=7, b=-2 -> lo=-3, hi=1.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, done pulse, no div_zero.
- Zero divisor: previous result lo=14, hi=2; then a=5, b=0 -> div_zero high exactly one cycle, busy stays 0, done stays 0, hi=2, lo=14 unchanged.
- Second start while busy:
  - Start 100/7, then at iteration 5 pulse start with a=9, b=3 -> ignored; single done with lo=14, hi=2.
  - A start issued in the done cycle with 9/3 -> accepted; lo=3, hi=0 after a further 33 edges.
- Reset during operation: reset=0 at iteration 10 -> next edge busy=0, done=0, hi=0, lo=0. After release, 100/7 completes normally.
- With DIV_UNSIGNED_EN: a=0xFFFFFFFF, b=2, div_unsigned=1 -> lo=0x7FFFFFFF, hi=1.
